bip_debug_unit: RTL and testbench
=================================

# bip_debug_unit

Post-execution debug unit for the BIP-I accumulator processor. It sits downstream of the processor core. It counts executed instructions and watches the decoder's halt indication. On halt, it freezes the core through a clock-enable, snapshots PC, ACC and the instruction count, and streams them as a byte frame to the UART transmitter over a valid/ready handshake.

## Interface

Parameters:
- `PC_BITS`, default 11: program counter width; must be ≤ 16.
- `DATA_BITS`, default 16: accumulator width; fixed at 16.
- `CNT_BITS`, default 16: instruction counter width; fixed at 16.

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Halt`  in  1  from the instruction decoder; high while the current instruction is HLT (opcode 00000).
- `Pc`  in  PC_BITS  current program counter from the core.
- `Acc`  in  DATA_BITS  current accumulator from the core.
- `Cpu_Enable`  out  1  enable for PC, ACC and data-memory writes; high only in RUN.
- `Tx_Data`  out  8  frame byte to the UART transmitter.
- `Tx_Valid`  out  1  `Tx_Data` is valid.
- `Tx_Ready`  in  1  transmitter accepts the byte.
- `Busy`  out  1  high in SEND.
- `Done`  out  1  high in DONE.

## Operation

- States are RUN, SEND and DONE. Reset forces RUN.
- **RUN:**
  - `Cpu_Enable`=1.
  - The instruction counter increments on every edge and saturates at 16'hFFFF.
  - On an edge where `Halt`=1, the unit captures the frame and goes to SEND. The counter value captured is counter+1 (saturating), so it includes the HLT instruction.
- **Frame capture:**
  - Byte order is PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0].
  - PC is zero-extended from PC_BITS to 16.
  - The captured frame is held in an internal register. Later changes on `Pc`/`Acc` do not affect it.
- **SEND:**
  - `Cpu_Enable`=0, `Busy`=1, `Tx_Valid`=1.
  - `Tx_Data` shows the byte at the current index.
  - A byte transfers on an edge where `Tx_Valid`=1 and `Tx_Ready`=1; the index then advances.
  - While `Tx_Ready`=0, `Tx_Data` and `Tx_Valid` hold stable.
  - A transfer of the last byte moves the unit to DONE.
- **DONE:**
  - `Cpu_Enable`=0, `Tx_Valid`=0, `Done`=1.
  - The unit stays in DONE until reset.
- `Halt` is ignored in SEND and DONE.
- `Tx_Ready` is ignored whenever `Tx_Valid`=0.

## Timing

- Reset values: state RUN, counter 0, byte index 0, frame register 0.
  - Outputs: `Cpu_Enable`=1, `Tx_Valid`=0, `Tx_Data`=8'h00, `Busy`=0, `Done`=0.
  - Reset is asynchronous: outputs take these values immediately on `Reset`=0, not at the next edge.
- Halt latency:
  - HLT is decoded in cycle n.
  - From cycle n+1: `Cpu_Enable`=0, `Tx_Valid`=1, `Tx_Data`=PC[15:8].
  - The core's edge at the end of cycle n is still enabled. This is harmless, because HLT writes neither ACC nor memory.
- With `Tx_Ready` tied high, one byte transfers per cycle. The last byte transfers at the end of cycle n+6, and `Done`=1 from cycle n+7.
- A `Halt` in the first cycle after reset release captures CNT=1.
- Counter saturation: after 65535 increments the counter stays at FFFF, and the captured CNT is FFFF.
- Reset asserted during SEND aborts the frame, with no partial completion. After release the unit restarts in RUN with the counter at 0.
- All outputs are registered. None depends combinationally on `Tx_Ready` or `Halt`.

## Configuration

- `BIP_DBG_CHECKSUM_EN`:
  - Defined: a 7th byte is appended, equal to the XOR of the six frame bytes. It is computed at capture time, and DONE follows transfer of byte 7.
  - Undefined: the frame is 6 bytes. No checksum logic is synthesized.

## Test plan

- **Basic frame:** reset, 4 RUN cycles, `Halt`=1 with Pc=11'h005, Acc=16'h1234, `Tx_Ready`=1 → bytes 00 05 12 34 00 05; `Done` is high 6 cycles after the first byte. With `BIP_DBG_CHECKSUM_EN` defined, a 7th byte 26.
- **Backpressure:** same frame with `Tx_Ready` low for 3 cycles before each byte → each byte holds stable while `Tx_Ready`=0 and transfers exactly once. No duplicates, no skips.
- **Immediate halt:** `Halt`=1 in the first cycle after reset release with Pc=0, Acc=0 → frame 00 00 00 00 00 01. `Cpu_Enable` falls one cycle later.
- **Saturation:** 70000 RUN cycles, then `Halt` with Pc=11'h7FF, Acc=16'hFFFF → frame 07 FF FF FF FF FF.
- **Reset mid-frame:** `Reset`=0 after byte 3 transfers → `Tx_Valid`=0 and `Cpu_Enable`=1 immediately. After release, a new halt at Pc=11'h002 yields CNT equal to the cycles since release, with no stale bytes.
- **Post-done inertness:** in DONE, toggle `Halt` and `Tx_Ready` for 20 cycles → `Tx_Valid` stays 0, `Done` stays 1, `Cpu_Enable` stays 0.

Source files
------------

// File: rtl/bip_debug_unit.sv
// bip_debug_unit: freezes the BIP-I core on HLT and streams PC/ACC/instruction count as a byte frame
// Define BIP_DBG_CHECKSUM_EN to append an XOR checksum byte to the frame.
module bip_debug_unit #(
    parameter int PC_BITS   = 11,
    parameter int DATA_BITS = 16,
    parameter int CNT_BITS  = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Halt,
    input  logic [PC_BITS-1:0]   Pc,
    input  logic [DATA_BITS-1:0] Acc,
    output logic                 Cpu_Enable,
    output logic [7:0]           Tx_Data,
    output logic                 Tx_Valid,
    input  logic                 Tx_Ready,
    output logic                 Busy,
    output logic                 Done
);
`ifdef BIP_DBG_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int FW = 8 * NB;
    localparam logic [2:0] LAST = 3'(NB - 1);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nx;
    logic [2:0]          idx;
    logic [FW-1:0]       frame;
    logic [FW-1:0]       cap;
    logic [47:0]         raw;

    assign cnt_nx = &cnt ? cnt : cnt + 1'b1;
    assign raw    = {16'(Pc), Acc, cnt_nx};
`ifdef BIP_DBG_CHECKSUM_EN
    assign cap = {raw, raw[47:40] ^ raw[39:32] ^ raw[31:24] ^ raw[23:16] ^ raw[15:8] ^ raw[7:0]};
`else
    assign cap = raw;
`endif

    // frame is a shift register: the head byte is always the one on offer
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_RUN;
            cnt   <= '0;
            idx   <= '0;
            frame <= '0;
        end else if (state == S_RUN) begin
            cnt <= cnt_nx;
            if (Halt) begin
                frame <= cap;
                state <= S_SEND;
            end
        end else if (state == S_SEND && Tx_Ready) begin
            frame <= frame << 8;
            idx   <= idx + 1'b1;
            if (idx == LAST) state <= S_DONE;
        end
    end

    assign Cpu_Enable = state == S_RUN;
    assign Tx_Valid   = state == S_SEND;
    assign Busy       = state == S_SEND;
    assign Done       = state == S_DONE;
    assign Tx_Data    = frame[FW-1 -: 8];
endmodule

// File: tb/tb_bip_debug_unit.sv
// tb_bip_debug_unit: scoreboard bench for bip_debug_unit frame capture, handshake and reset
module tb_bip_debug_unit;
    logic        Clk, Reset, Halt, Tx_Ready;
    logic [10:0] Pc;
    logic [15:0] Acc;
    logic        Cpu_Enable, Tx_Valid, Busy, Done;
    logic [7:0]  Tx_Data;
    logic [7:0]  q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    bip_debug_unit dut (
        .Clk(Clk), .Reset(Reset), .Halt(Halt), .Pc(Pc), .Acc(Acc),
        .Cpu_Enable(Cpu_Enable), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
        .Tx_Ready(Tx_Ready), .Busy(Busy), .Done(Done)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 0;
        Halt = 0;
        Tx_Ready = 0;
        #1;
        chk("rst_cpu_en", Cpu_Enable, 1);
        chk("rst_valid", Tx_Valid, 0);
        chk("rst_data", Tx_Data, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        q.delete();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (i < 8) chk("run_cpu_en", Cpu_Enable, 1);
        end
    endtask

    task automatic push_frame(input logic [15:0] pc, input logic [15:0] acc, input logic [15:0] cnt);
        logic [7:0] b[6];
        logic [7:0] x;
        b = '{pc[15:8], pc[7:0], acc[15:8], acc[7:0], cnt[15:8], cnt[7:0]};
        x = 0;
        for (int i = 0; i < 6; i++) begin
            q.push_back(b[i]);
            x ^= b[i];
        end
`ifdef BIP_DBG_CHECKSUM_EN
        q.push_back(x);
`endif
    endtask

    task automatic halt(input logic [10:0] pc, input logic [15:0] acc, input logic [15:0] cnt);
        chk("pre_halt_cpu_en", Cpu_Enable, 1);
        Pc = pc;
        Acc = acc;
        Halt = 1;
        push_frame({5'b0, pc}, acc, cnt);
        @(negedge Clk);
        Halt = 0;
        Pc = 11'($urandom);
        Acc = 16'($urandom);
        chk("halt_cpu_en", Cpu_Enable, 0);
        chk("halt_busy", Busy, 1);
    endtask

    task automatic send(input int stall, input int limit);
        int st = 0;
        int sent = 0;
        int guard = 0;
        while (q.size() > 0 && sent < limit && guard < 200) begin
            chk("valid", Tx_Valid, 1);
            if (st < stall) begin
                Tx_Ready = 0;
                chk("hold_data", Tx_Data, q[0]);
                st++;
            end else begin
                Tx_Ready = 1;
                chk("byte", Tx_Data, q.pop_front());
                st = 0;
                sent++;
            end
            @(negedge Clk);
            guard++;
        end
        chk("send_timeout", guard < 200, 1);
        Tx_Ready = 0;
    endtask

    task automatic check_done();
        chk("done", Done, 1);
        chk("done_valid", Tx_Valid, 0);
        chk("done_busy", Busy, 0);
        chk("done_cpu_en", Cpu_Enable, 0);
    endtask

    initial begin
        Reset = 1;
        Halt = 0;
        Tx_Ready = 0;
        Pc = 0;
        Acc = 0;
        @(negedge Clk);
        do_reset();
        Tx_Ready = 1;
        run(4);
        halt(11'h005, 16'h1234, 16'd5);
        send(0, 99);
        check_done();

        do_reset();
        run(2);
        halt(11'h005, 16'h1234, 16'd3);
        send(3, 99);
        check_done();

        do_reset();
        halt(11'h000, 16'h0000, 16'd1);
        send(0, 99);
        check_done();

        do_reset();
        run(70000);
        halt(11'h7FF, 16'hFFFF, 16'hFFFF);
        send(1, 99);
        check_done();

        do_reset();
        run(1);
        halt(11'h003, 16'hABCD, 16'd2);
        send(0, 3);
        do_reset();
        run(2);
        halt(11'h002, 16'h0055, 16'd3);
        send(1, 99);
        check_done();

        for (int i = 0; i < 20; i++) begin
            Halt = 1'($urandom);
            Tx_Ready = 1'($urandom);
            @(negedge Clk);
            check_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
